// File: rtl/mem_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Module : mem_arbiter_if
// Brief  : Requester (dc / if) and single-ported memory bus of mem_arbiter.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
    logic        dc_req;
    logic        dc_we;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic        dc_ack;
    logic [31:0] dc_rdata;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        owner;

    // arbiter side
    modport slave (
        input  dc_req, dc_we, dc_addr, dc_wdata, if_req, if_addr, mem_rdata,
        output dc_ack, dc_rdata, if_ack, if_rdata, mem_addr, mem_wdata, mem_we,
               busy, owner
    );

    // requester + memory side
    modport master (
        output dc_req, dc_we, dc_addr, dc_wdata, if_req, if_addr, mem_rdata,
        input  dc_ack, dc_rdata, if_ack, if_rdata, mem_addr, mem_wdata, mem_we,
               busy, owner
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Module : mem_arbiter
// Brief  : Two-requester (dc priority, if anti-starvation) fixed-latency
//          arbiter onto one single-ported main-memory interface.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MEM_LATENCY  = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  wire logic    clk,
    input  wire logic    rst_b,
    mem_arbiter_if.slave bus
);
    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [LAT_W-1:0] c_LAT_LOAD   = LAT_W'(MEM_LATENCY - 1);
    localparam logic [SC_W-1:0]  c_STARVE_MAX = SC_W'(STARVE_LIMIT);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [LAT_W-1:0] r_lat_cnt;
    logic [SC_W-1:0]  r_starve_cnt;
    logic             r_owner;
    logic             r_we_q;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [31:0]      r_dc_rdata;
    logic [31:0]      r_if_rdata;

    logic w_any_req;
    logic w_grant_if;
    logic w_lat_zero;
    logic w_mem_we;
    logic w_dc_ack;
    logic w_if_ack;
    logic w_busy;

    assign w_any_req  = bus.dc_req | bus.if_req;
    // fetch wins when alone, or when dc has won STARVE_LIMIT contested rounds
    assign w_grant_if = bus.if_req & (~bus.dc_req | (r_starve_cnt == c_STARVE_MAX));
    assign w_lat_zero = (r_lat_cnt == '0);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_any_req)  w_next_state = c_BUSY;
            c_BUSY:  if (w_lat_zero) w_next_state = c_DONE;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = (r_state != c_IDLE);
        w_dc_ack = (r_state == c_DONE) & ~r_owner;
        w_if_ack = (r_state == c_DONE) &  r_owner;
        // counter still at its load value only in the first BUSY cycle
        w_mem_we = (r_state == c_BUSY) & (r_lat_cnt == c_LAT_LOAD) & r_we_q;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_lat_cnt    <= '0;
            r_starve_cnt <= '0;
            r_owner      <= 1'b0;
            r_we_q       <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_dc_rdata   <= '0;
            r_if_rdata   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_owner   <= w_grant_if;
                        r_lat_cnt <= c_LAT_LOAD;
                        if (w_grant_if) begin
                            r_mem_addr   <= bus.if_addr;
                            r_we_q       <= 1'b0;
                            r_starve_cnt <= '0;
                        end else begin
                            r_mem_addr  <= bus.dc_addr;
                            r_mem_wdata <= bus.dc_wdata;
                            r_we_q      <= bus.dc_we;
                            if (!bus.if_req) begin
                                r_starve_cnt <= '0;
                            end else if (r_starve_cnt != c_STARVE_MAX) begin
                                r_starve_cnt <= r_starve_cnt + SC_W'(1);
                            end
                        end
                    end
                end
                c_BUSY: begin
                    if (!w_lat_zero) begin
                        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    end else if (!r_we_q) begin
                        if (r_owner) r_if_rdata <= bus.mem_rdata;
                        else         r_dc_rdata <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dc_ack    = w_dc_ack;
    assign bus.if_ack    = w_if_ack;
    assign bus.dc_rdata  = r_dc_rdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_we    = w_mem_we;
    assign bus.busy      = w_busy;
    assign bus.owner     = r_owner;
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Module : tb_mem_arbiter
// Brief  : Directed scoreboard bench for mem_arbiter (latency 4 and 1 builds).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    localparam int LAT = 4;

    typedef struct {
        bit          owner;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_b;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t mon_e;
    bit   ord[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    mem_arbiter_if u_if ();
    mem_arbiter_if u_if1 ();

    mem_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(3)) u_dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (u_if.slave)
    );

    mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(3)) u_dut1 (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (u_if1.slave)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hA5A5_5A5A);
    endfunction

    // memory model: data for the presented address is always available
    assign u_if.mem_rdata  = pat(u_if.mem_addr);
    assign u_if1.mem_rdata = pat(u_if1.mem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the cycle the request is sampled; returns in the ack cycle.
    task automatic txn(input string tag, input bit own, input bit we, input logic [31:0] addr);
        for (int k = 1; k <= LAT; k++) begin
            step();
            chk({tag, "_ack_early"}, {30'd0, u_if.dc_ack, u_if.if_ack}, 32'd0);
            chk({tag, "_we"}, {31'd0, u_if.mem_we}, {31'd0, (k == 1) ? we : 1'b0});
            if (k == 1) begin
                chk({tag, "_addr"},  u_if.mem_addr, addr);
                chk({tag, "_owner"}, {31'd0, u_if.owner}, {31'd0, own});
                chk({tag, "_busy"},  {31'd0, u_if.busy}, 32'd1);
            end
        end
        step();
        chk({tag, "_ack"}, {31'd0, own ? u_if.if_ack : u_if.dc_ack}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_b === 1'b1 && (u_if.dc_ack || u_if.if_ack)) begin
            chk("ack_exclusive", {31'd0, u_if.dc_ack & u_if.if_ack}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'd0, u_if.dc_ack, u_if.if_ack}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_owner", {31'd0, u_if.if_ack}, {31'd0, mon_e.owner});
                if (mon_e.rd)
                    chk("sb_rdata", mon_e.owner ? u_if.if_rdata : u_if.dc_rdata, mon_e.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b          = 1'b0;
        u_if.dc_req    = 1'b0;
        u_if.dc_we     = 1'b0;
        u_if.dc_addr   = '0;
        u_if.dc_wdata  = '0;
        u_if.if_req    = 1'b0;
        u_if.if_addr   = '0;
        u_if1.dc_req   = 1'b0;
        u_if1.dc_we    = 1'b0;
        u_if1.dc_addr  = '0;
        u_if1.dc_wdata = '0;
        u_if1.if_req   = 1'b0;
        u_if1.if_addr  = '0;
        step();
        step();
        chk("rst_busy",  {31'd0, u_if.busy}, 32'd0);
        chk("rst_owner", {31'd0, u_if.owner}, 32'd0);
        chk("rst_addr",  u_if.mem_addr, 32'd0);
        chk("rst_wdata", u_if.mem_wdata, 32'd0);
        chk("rst_acks",  {29'd0, u_if.dc_ack, u_if.if_ack, u_if.mem_we}, 32'd0);
        chk("rst_dcrd",  u_if.dc_rdata, 32'd0);
        chk("rst_ifrd",  u_if.if_rdata, 32'd0);
        rst_b = 1'b1;
        step();

        // dc read
        u_if.dc_req = 1'b1; u_if.dc_we = 1'b0; u_if.dc_addr = 32'h100;
        sb.push_back('{owner: 1'b0, rd: 1'b1, data: 32'hDEADBEEF});
        txn("t1", 1'b0, 1'b0, 32'h100);
        chk("t1_rdata", u_if.dc_rdata, 32'hDEADBEEF);
        u_if.dc_req = 1'b0;
        step();

        // dc write leaves dc_rdata alone
        u_if.dc_req = 1'b1; u_if.dc_we = 1'b1; u_if.dc_addr = 32'h200; u_if.dc_wdata = 32'h12345678;
        sb.push_back('{owner: 1'b0, rd: 1'b0, data: 32'h0});
        txn("t2", 1'b0, 1'b1, 32'h200);
        chk("t2_wdata", u_if.mem_wdata, 32'h12345678);
        chk("t2_rdata", u_if.dc_rdata, 32'hDEADBEEF);
        u_if.dc_req = 1'b0; u_if.dc_we = 1'b0;
        step();

        // simultaneous requests: dc first, then if
        u_if.dc_req = 1'b1; u_if.dc_addr = 32'h300;
        u_if.if_req = 1'b1; u_if.if_addr = 32'h400;
        sb.push_back('{owner: 1'b0, rd: 1'b1, data: pat(32'h300)});
        sb.push_back('{owner: 1'b1, rd: 1'b1, data: pat(32'h400)});
        txn("t3dc", 1'b0, 1'b0, 32'h300);
        u_if.dc_req = 1'b0;
        step();
        chk("t3_idle", {31'd0, u_if.busy}, 32'd0);
        txn("t3if", 1'b1, 1'b0, 32'h400);
        chk("t3_ifrd", u_if.if_rdata, pat(32'h400));
        u_if.if_req = 1'b0;
        step();

        // starvation: dc, dc, dc, if, dc
        u_if.dc_req = 1'b1; u_if.dc_addr = 32'h500;
        u_if.if_req = 1'b1; u_if.if_addr = 32'h600;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{owner: ord[i], rd: 1'b1, data: pat(ord[i] ? 32'h600 : 32'h500)});
            txn("t4", ord[i], 1'b0, ord[i] ? 32'h600 : 32'h500);
            if (i == 2) chk("t4_starve_sat", 32'(u_dut.r_starve_cnt), 32'd3);
            if (i == 3) begin
                chk("t4_starve_clr", 32'(u_dut.r_starve_cnt), 32'd0);
                u_if.if_req = 1'b0;
            end
            if (i == 4) u_if.dc_req = 1'b0;
            step();
        end

        // async reset mid-transaction
        u_if.dc_req = 1'b1; u_if.dc_addr = 32'h100;
        step();
        step();
        rst_b = 1'b0;
        #1;
        u_if.dc_req = 1'b0;
        chk("t5_busy",  {31'd0, u_if.busy}, 32'd0);
        chk("t5_owner", {31'd0, u_if.owner}, 32'd0);
        chk("t5_addr",  u_if.mem_addr, 32'd0);
        chk("t5_wdata", u_if.mem_wdata, 32'd0);
        chk("t5_acks",  {29'd0, u_if.dc_ack, u_if.if_ack, u_if.mem_we}, 32'd0);
        chk("t5_dcrd",  u_if.dc_rdata, 32'd0);
        chk("t5_ifrd",  u_if.if_rdata, 32'd0);
        step();
        rst_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t5_no_ack", {30'd0, u_if.dc_ack, u_if.if_ack}, 32'd0);
        end
        u_if.if_req = 1'b1; u_if.if_addr = 32'h700;
        sb.push_back('{owner: 1'b1, rd: 1'b1, data: pat(32'h700)});
        txn("t5if", 1'b1, 1'b0, 32'h700);
        chk("t5_ifrd2", u_if.if_rdata, pat(32'h700));
        u_if.if_req = 1'b0;
        step();

        // latency-1 build
        u_if1.if_req = 1'b1; u_if1.if_addr = 32'h800;
        step();
        chk("t6_addr",  u_if1.mem_addr, 32'h800);
        chk("t6_state", {29'd0, u_if1.busy, u_if1.owner, u_if1.if_ack}, 32'd6);
        step();
        chk("t6_ack",   {31'd0, u_if1.if_ack}, 32'd1);
        chk("t6_ifrd",  u_if1.if_rdata, pat(32'h800));
        u_if1.if_req = 1'b0;
        step();
        chk("t6_pulse", {31'd0, u_if1.if_ack}, 32'd0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported main-memory interface between two requesters: the data cache's refill/write-back path (dc) and instruction fetch (if).
- Sits between the core/cache and the memory model. Each transaction is registered, the memory is sequenced for a fixed latency, and the result is returned with a one-cycle ack pulse.
- Data requests have priority. A starvation counter guarantees fetch progress.

Parameters:
- MEM_LATENCY, 4, memory cycles from address presentation to valid mem_rdata (legal range ≥1).
- STARVE_LIMIT, 3, consecutive contested dc grants after which a pending if request wins (legal range ≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  asynchronous active-low reset.
- dc_req  in  1  data request (level); held until dc_ack.
- dc_we  in  1  1 = write, 0 = read; valid with dc_req.
- dc_addr  in  32  data byte address.
- dc_wdata  in  32  write data; bits 31:24 = byte 0 (big-endian byte lanes).
- dc_ack  out  1  one-cycle completion pulse.
- dc_rdata  out  32  read data; valid from dc_ack, held until the next dc read completes.
- if_req  in  1  fetch request (read only), held until if_ack.
- if_addr  in  32  fetch address.
- if_ack  out  1  one-cycle completion pulse.
- if_rdata  out  32  fetched word; held like dc_rdata.
- mem_addr  out  32  memory address (registered).
- mem_wdata  out  32  memory write data (registered).
- mem_we  out  1  memory write strobe.
- mem_rdata  in  32  memory read data.
- busy  out  1  transaction in progress (BUSY or DONE state).
- owner  out  1  0 = dc, 1 = if; meaningful only while busy.

Behaviour:
- Reset (async, any state):
  - State returns to IDLE; any outstanding transaction is dropped with no ack.
  - All outputs and registers are 0, including the starvation counter.
- States are IDLE, BUSY and DONE.
- IDLE:
  - Requests are sampled only in this state.
  - If dc_req or if_req is high, the grant is chosen, the transaction is latched into mem_addr / mem_wdata / owner (and we_q), the latency counter loads MEM_LATENCY−1, and the state moves to BUSY.
  - With no request, the block stays in IDLE and outputs hold.
- Grant rule:
  - Only one request high → that requester wins.
  - Both high → dc wins, unless starve_cnt == STARVE_LIMIT, in which case if wins.
- Starvation counter:
  - On a dc grant with if_req high: increment, saturating at STARVE_LIMIT.
  - On a dc grant with if_req low: clear.
  - On any if grant: clear.
  - Width is clog2(STARVE_LIMIT+1).
- BUSY:
  - mem_we = we_q only in the first BUSY cycle, so a write strobe lasts exactly one cycle; an if transaction never writes.
  - The counter decrements each cycle.
  - When the counter is 0: if the transaction is a read, capture mem_rdata into dc_rdata or if_rdata according to owner, then go to DONE.
  - BUSY lasts exactly MEM_LATENCY cycles.
- DONE:
  - Pulse the owner's ack for one cycle, then go to IDLE.
  - Requests are ignored in DONE.
  - A requester still holding req in the cycle after its ack is treated as a new request.
- Timing:
  - A request seen in IDLE at cycle T gives mem_addr valid from T+1 and ack at T+MEM_LATENCY+1.
  - Back-to-back throughput is one transaction per MEM_LATENCY+2 cycles.
- Writes do not modify dc_rdata.
- mem_addr and mem_wdata hold their last value outside BUSY.
- dc_ack and if_ack are never high in the same cycle.
- Request inputs changing during BUSY or DONE have no effect on the in-flight transaction.

Test Plan:
1. dc read at 0x100, memory returns 0xDEADBEEF (MEM_LATENCY=4) → mem_addr=0x100 from T+1; dc_ack only at T+5; dc_rdata=0xDEADBEEF; mem_we never high.
2. dc write of 0x12345678 to 0x200 → mem_we high exactly at T+1; mem_wdata=0x12345678; dc_ack at T+5; dc_rdata unchanged.
3. dc_req and if_req raised together at T → dc served first (dc_ack T+5); if granted at T+6, owner=1, if_ack at T+11.
4. dc_req held continuously with if_req also high (STARVE_LIMIT=3) → grant order dc, dc, dc, if, dc; starve_cnt returns to 0 after the if grant.
5. rst_b pulsed low at T+2 of a dc read → all outputs 0 immediately; no dc_ack; a fresh if read after reset completes normally in 5 cycles.
6. MEM_LATENCY=1 build, single if read at T → mem_addr valid at T+1; if_ack at T+2 with correct if_rdata.
